// File: rtl/sram_async_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_async_ctrl
// Purpose  : Single-request handshake controller for an asynchronous SRAM/PSRAM.
//            Setup, strobe and recovery timing are programmable, and all pin
//            outputs are registered.
// Revision : 1.0
// ============================================================================
module sram_async_ctrl #(
    parameter  int ADDR_W      = 23,
    parameter  int DATA_W      = 16,
    parameter  int SETUP_CYC   = 1,
    parameter  int ACCESS_CYC  = 7,
    parameter  int RECOVER_CYC = 2,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy_rd,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              ce_n,
    output logic              we_n,
    output logic              oe_n,
    output logic [BE_W-1:0]   be_n,
    output logic              sram_clk,
    output logic              adv_n,
    output logic              cre
);

    localparam int MAX_SA  = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
    localparam int MAX_CYC = (MAX_SA > RECOVER_CYC) ? MAX_SA : RECOVER_CYC;
    localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_ACCESS  = CNT_W'(ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RECOVER = CNT_W'(RECOVER_CYC - 1);

    if ((DATA_W % 8 != 0) || (SETUP_CYC < 1) || (ACCESS_CYC < 1) || (RECOVER_CYC < 1)) begin : g_param_check
        $error("sram_async_ctrl: DATA_W must be a multiple of 8 and all cycle counts >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                ack_q, ack_d;
    logic                busy_rd_q, busy_rd_d;
    logic                ce_n_q, ce_n_d;
    logic                we_n_q, we_n_d;
    logic                oe_n_q, oe_n_d;
    logic [BE_W-1:0]     be_n_q, be_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic                active_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SETUP;
                    cnt_d   = LD_SETUP;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    addr_d  = req_addr;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = LD_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    // Last strobe cycle: OE is still low, so the bus holds valid read data.
                    if (!we_q) begin
                        rdata_d = sram_dq;
                    end
                    state_d = ST_RECOVER;
                    cnt_d   = LD_RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin outputs are decoded from the next state so they line up with it once registered.
        active_d  = (state_d == ST_SETUP) || (state_d == ST_STROBE);
        ready_d   = (state_d == ST_IDLE);
        ack_d     = (state_q == ST_STROBE) && (state_d == ST_RECOVER);
        busy_rd_d = (state_d != ST_IDLE) && !we_d;
        ce_n_d    = !active_d;
        we_n_d    = !((state_d == ST_STROBE) && we_d);
        oe_n_d    = !((state_d == ST_STROBE) && !we_d);
        be_n_d    = active_d ? ~be_d : '1;
        // Write data is held one cycle past the strobe so the part sees hold time after WE rises.
        dq_oe_d   = we_d && (active_d || ack_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b1;
            ack_q     <= 1'b0;
            busy_rd_q <= 1'b0;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            be_n_q    <= '1;
            dq_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
            busy_rd_q <= busy_rd_d;
            ce_n_q    <= ce_n_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            be_n_q    <= be_n_d;
            dq_oe_q   <= dq_oe_d;
        end
    end

    assign ready     = ready_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy_rd   = busy_rd_q;
    assign sram_addr = addr_q;
    assign ce_n      = ce_n_q;
    assign we_n      = we_n_q;
    assign oe_n      = oe_n_q;
    assign be_n      = be_n_q;
    assign sram_dq   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

    assign sram_clk  = 1'b0;
    assign adv_n     = 1'b0;
    assign cre       = 1'b0;

endmodule
`default_nettype wire
